// File: rtl/irq_arbiter.sv
// irq_arbiter: latches NSRC external lines plus timer as pending, picks one
// winner at a time and presents it over eip; CSR window for mask/pending/id/drops.
module irq_arbiter #(
  parameter int NSRC    = 4,
  parameter int RR      = 1,
  parameter int TIMEOUT = 255,
  parameter int GAP     = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [NSRC-1:0] irq_in,
  input  logic            timer_irq,
  input  logic [1:0]      a,
  input  logic [31:0]     d,
  input  logic            we,
  output logic [31:0]     spo,
  output logic            eip,
  output logic            eip_istimer,
  input  logic            eip_reply,
  output logic [4:0]      claim_id
);

  localparam int PW = (NSRC > 1) ? $clog2(NSRC) : 1;
  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam int GW = (GAP > 1) ? $clog2(GAP) : 1;
  localparam logic [31:0] IMPL =
    32'h8000_0000 | ((32'h1 << NSRC) - 32'h1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SEL,
    S_REQ,
    S_GAP
  } state_t;

  state_t state, state_nx;

  logic [NSRC-1:0] irq_s, irq_h;
  logic            tmr_s, tmr_h;
  logic [31:0]     pending, enable;
  logic [31:0]     pend_nx, en_nx;
  logic [31:0]     set_v, clr_v, elig_sel;
  logic [15:0]     drop_cnt;
  logic [4:0]      win_id, pick_id;
  logic [PW-1:0]   rr_ptr, rr_nx;
  logic [TW-1:0]   tcnt;
  logic [GW-1:0]   gcnt;
  logic            acc, to_hit, req_exit, found;
  logic            wr_en, wr_pend, wr_drop;
  int              idx, nxt;

  assign wr_en   = we && (a == 2'd0);
  assign wr_pend = we && (a == 2'd1);
  assign wr_drop = we && (a == 2'd3);

  assign acc      = (state == S_REQ) && eip_reply;
  assign to_hit   = (state == S_REQ) && !eip_reply
                    && (tcnt == TW'(TIMEOUT - 1));
  assign req_exit = acc || to_hit;

  // Rising edges set pending; W1C and accept clear; a set in the same cycle wins.
  always_comb begin
    set_v = '0;
    set_v[NSRC-1:0] = irq_s & ~irq_h;
    set_v[31] = tmr_s & ~tmr_h;
    clr_v = wr_pend ? d : '0;
    if (acc) clr_v = clr_v | (32'h1 << win_id);
    pend_nx = ((pending & ~clr_v) | set_v) & IMPL;
    en_nx = wr_en ? (d & IMPL) : enable;
    elig_sel = pend_nx & en_nx;
  end

  // Winner pick: timer first, then first eligible source from the rotation base.
  always_comb begin
    pick_id = '0;
    found = 1'b0;
    idx = 0;
    if (elig_sel[31]) begin
      pick_id = 5'd31;
    end else begin
      for (int k = 0; k < NSRC; k++) begin
        idx = (RR != 0) ? ((int'(rr_ptr) + k) % NSRC) : k;
        if (!found && elig_sel[idx[4:0]]) begin
          found = 1'b1;
          pick_id = idx[4:0];
        end
      end
    end
  end

  // Rotation pointer moves just past the last external winner.
  always_comb begin
    nxt = (int'(win_id) + 1) % NSRC;
    rr_nx = nxt[PW-1:0];
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nx;
  end

  // FSM next-state logic.
  always_comb begin
    state_nx = state;
    unique case (state)
      S_IDLE: if (|(pending & enable)) state_nx = S_SEL;
      S_SEL:  state_nx = (elig_sel == '0) ? S_IDLE : S_REQ;
      S_REQ: begin
        if (req_exit) state_nx = (GAP == 0) ? S_IDLE : S_GAP;
      end
      S_GAP:  if (gcnt == GW'(GAP - 1)) state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  // FSM outputs: request is held stable for the whole REQ state.
  always_comb begin
    eip = (state == S_REQ);
    eip_istimer = (state == S_REQ) && (win_id == 5'd31);
  end

  // Datapath: sync, pending, mask, counters, winner and claim bookkeeping.
  always_ff @(posedge clk) begin
    if (rst) begin
      irq_s    <= '0;
      irq_h    <= '0;
      tmr_s    <= 1'b0;
      tmr_h    <= 1'b0;
      pending  <= '0;
      enable   <= '0;
      drop_cnt <= '0;
      win_id   <= '0;
      claim_id <= '0;
      rr_ptr   <= '0;
      tcnt     <= '0;
      gcnt     <= '0;
    end else begin
      irq_s   <= irq_in;
      irq_h   <= irq_s;
      tmr_s   <= timer_irq;
      tmr_h   <= tmr_s;
      pending <= pend_nx;
      enable  <= en_nx;
      if (wr_drop) drop_cnt <= '0;
      else if (to_hit && drop_cnt != 16'hFFFF)
        drop_cnt <= drop_cnt + 16'd1;
      if (state == S_SEL) begin
        win_id <= pick_id;
        tcnt <= '0;
      end else if (state == S_REQ && !req_exit) begin
        tcnt <= tcnt + TW'(1);
      end
      if (req_exit) begin
        gcnt <= '0;
        if (win_id != 5'd31) rr_ptr <= rr_nx;
      end else if (state == S_GAP) begin
        gcnt <= gcnt + GW'(1);
      end
      if (acc) claim_id <= win_id;
    end
  end

  // Register read port, combinational from the address.
  always_comb begin
    spo = '0;
    unique case (a)
      2'd0: spo = enable;
      2'd1: spo = pending;
      2'd2: spo = {27'd0, claim_id};
      2'd3: spo = {16'd0, drop_cnt};
      default: spo = '0;
    endcase
  end

endmodule

// File: tb/tb_irq_arbiter.sv
// tb_irq_arbiter: directed scenarios plus random traffic, every cycle
// compared against a transaction-level model of the arbiter.
module tb_irq_arbiter;

  localparam int NSRC = 4;
  localparam int RR = 1;
  localparam int TIMEOUT = 255;
  localparam int GAP = 2;

  localparam int M_IDLE = 0;
  localparam int M_SEL = 1;
  localparam int M_REQ = 2;
  localparam int M_GAP = 3;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic [NSRC-1:0] irq_in = '0;
  logic            timer_irq = 1'b0;
  logic [1:0]      a = '0;
  logic [31:0]     d = '0;
  logic            we = 1'b0;
  logic            eip_reply = 1'b0;
  logic [31:0]     spo;
  logic            eip;
  logic            eip_istimer;
  logic [4:0]      claim_id;

  irq_arbiter #(
    .NSRC(NSRC), .RR(RR), .TIMEOUT(TIMEOUT), .GAP(GAP)
  ) dut (
    .clk(clk), .rst(rst), .irq_in(irq_in), .timer_irq(timer_irq),
    .a(a), .d(d), .we(we), .spo(spo), .eip(eip),
    .eip_istimer(eip_istimer), .eip_reply(eip_reply),
    .claim_id(claim_id)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  // reference model state
  bit [31:0]     m_pend = '0, m_en = '0;
  bit [15:0]     m_drop = '0;
  bit [4:0]      m_claim = '0, m_win = '0;
  int            m_rr = 0, m_phase = M_IDLE, m_age = 0, m_gap = 0;
  bit [NSRC-1:0] m_s = '0, m_h = '0;
  bit            m_ts = 1'b0, m_th = 1'b0;

  function automatic bit [31:0] impl_mask();
    bit [31:0] m;
    m = 32'h8000_0000;
    for (int i = 0; i < NSRC; i++) m[i] = 1'b1;
    return m;
  endfunction

  function automatic bit [4:0] pick(bit [31:0] e, int rr);
    int id;
    if (e[31]) return 5'd31;
    for (int k = 0; k < NSRC; k++) begin
      id = (RR != 0) ? (rr + k) % NSRC : k;
      if (e[id]) return 5'(id);
    end
    return 5'd0;
  endfunction

  task automatic finish_req();
    if (m_win != 5'd31) m_rr = (int'(m_win) + 1) % NSRC;
    m_gap = GAP;
    m_phase = (GAP == 0) ? M_IDLE : M_GAP;
  endtask

  task automatic model_step();
    bit [31:0] set_b, clr_b, pn, en_n, e;
    bit took;
    if (rst) begin
      m_pend = '0; m_en = '0; m_drop = '0; m_claim = '0;
      m_win = '0; m_rr = 0; m_phase = M_IDLE; m_age = 0;
      m_gap = 0; m_s = '0; m_h = '0; m_ts = 0; m_th = 0;
      return;
    end
    set_b = '0;
    for (int i = 0; i < NSRC; i++)
      if (m_s[i] && !m_h[i]) set_b[i] = 1'b1;
    if (m_ts && !m_th) set_b[31] = 1'b1;
    clr_b = (we && a == 2'd1) ? d : '0;
    took = (m_phase == M_REQ) && eip_reply;
    if (took) clr_b[m_win] = 1'b1;
    pn = ((m_pend & ~clr_b) | set_b) & impl_mask();
    en_n = (we && a == 2'd0) ? (d & impl_mask()) : m_en;
    case (m_phase)
      M_IDLE: if ((m_pend & m_en) != 0) m_phase = M_SEL;
      M_SEL: begin
        e = pn & en_n;
        if (e == 0) m_phase = M_IDLE;
        else begin
          m_win = pick(e, m_rr);
          m_age = 0;
          m_phase = M_REQ;
        end
      end
      M_REQ: begin
        if (took) begin
          m_claim = m_win;
          finish_req();
        end else if (m_age == TIMEOUT - 1) begin
          if (m_drop != 16'hFFFF) m_drop++;
          finish_req();
        end else begin
          m_age++;
        end
      end
      default: begin
        m_gap--;
        if (m_gap == 0) m_phase = M_IDLE;
      end
    endcase
    if (we && a == 2'd3) m_drop = '0;
    m_pend = pn;
    m_en = en_n;
    m_h = m_s;
    m_s = irq_in;
    m_th = m_ts;
    m_ts = timer_irq;
  endtask

  always @(posedge clk) model_step();

  function automatic bit [31:0] m_spo();
    case (a)
      2'd0: return m_en;
      2'd1: return m_pend;
      2'd2: return {27'd0, m_claim};
      default: return {16'd0, m_drop};
    endcase
  endfunction

  task automatic tick();
    @(negedge clk);
    chk("eip", eip, m_phase == M_REQ);
    chk("istimer", eip_istimer, (m_phase == M_REQ) && (m_win == 5'd31));
    chk("claim_id", claim_id, m_claim);
    chk("spo", spo, m_spo());
  endtask

  task automatic do_reset();
    rst = 1'b1; irq_in = '0; timer_irq = 0;
    we = 0; eip_reply = 0; a = 2'd0; d = '0;
    tick(); tick();
    rst = 1'b0;
  endtask

  task automatic wr(bit [1:0] addr, bit [31:0] data);
    a = addr; d = data; we = 1'b1;
    tick();
    we = 1'b0;
  endtask

  task automatic wait_eip(string tag);
    for (int n = 0; n < 20; n++) begin
      if (eip) return;
      tick();
    end
    chk(tag, eip, 1'b1);
  endtask

  int hi;

  initial begin
    // reset state
    tick();
    chk("rst_eip", eip, 1'b0);
    chk("rst_claim", claim_id, 5'd0);
    do_reset();

    // single source: 4-cycle latency, accept clears pending
    wr(2'd0, 32'h1);
    irq_in = 4'b0001;
    for (int i = 1; i <= 3; i++) begin
      tick();
      chk("t1_lat_lo", eip, 1'b0);
    end
    tick();
    chk("t1_eip", eip, 1'b1);
    chk("t1_ist", eip_istimer, 1'b0);
    eip_reply = 1'b1; a = 2'd1;
    tick();
    eip_reply = 1'b0;
    chk("t1_eip_lo", eip, 1'b0);
    chk("t1_claim", claim_id, 5'd0);
    chk("t1_pend", spo, 32'h0);

    // timer and source 2 same cycle: timer first, source 2 after gap
    do_reset();
    wr(2'd0, 32'h8000_000F);
    irq_in = 4'b0100; timer_irq = 1'b1;
    tick(); tick(); tick(); tick();
    chk("t2_eip", eip, 1'b1);
    chk("t2_ist", eip_istimer, 1'b1);
    eip_reply = 1'b1;
    tick();
    eip_reply = 1'b0;
    chk("t2_claim_t", claim_id, 5'd31);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("t2_gap", eip, 1'b0);
    end
    tick();
    chk("t2_eip2", eip, 1'b1);
    chk("t2_ist2", eip_istimer, 1'b0);
    eip_reply = 1'b1;
    tick();
    eip_reply = 1'b0;
    chk("t2_claim_s", claim_id, 5'd2);

    // round robin over four held sources
    do_reset();
    wr(2'd0, 32'hF);
    irq_in = 4'hF;
    for (int k = 0; k < 4; k++) begin
      wait_eip("t3_wait");
      tick(); tick(); tick();
      eip_reply = 1'b1;
      tick();
      eip_reply = 1'b0;
      chk("t3_claim", claim_id, 5'(k));
    end
    irq_in = 4'h0;
    tick();
    irq_in = 4'hF;
    wait_eip("t3_wait5");
    eip_reply = 1'b1;
    tick();
    eip_reply = 1'b0;
    chk("t3_claim5", claim_id, 5'd0);

    // timeout: drop, keep pending, re-request after gap
    do_reset();
    wr(2'd0, 32'h1);
    irq_in = 4'b0001;
    wait_eip("t4_wait");
    hi = 0;
    for (int n = 0; n < 400; n++) begin
      if (!eip) break;
      hi++;
      tick();
    end
    chk("t4_high", hi, TIMEOUT);
    a = 2'd3;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("t4_gap", eip, 1'b0);
    end
    chk("t4_drop", spo, 32'd1);
    a = 2'd1;
    tick();
    chk("t4_rereq", eip, 1'b1);
    chk("t4_pend", spo, 32'h1);
    eip_reply = 1'b1;
    tick();
    eip_reply = 1'b0;

    // W1C of the only eligible bit during SEL: no request
    do_reset();
    wr(2'd0, 32'h1);
    irq_in = 4'b0001;
    tick(); tick(); tick();
    wr(2'd1, 32'h1);
    for (int i = 0; i < 6; i++) begin
      tick();
      chk("t5_noeip", eip, 1'b0);
    end

    // reset during REQ
    do_reset();
    wr(2'd0, 32'h1);
    irq_in = 4'b0001;
    wait_eip("t6_wait");
    rst = 1'b1; a = 2'd0;
    tick();
    rst = 1'b0;
    chk("t6_eip", eip, 1'b0);
    chk("t6_en", spo, 32'h0);
    for (int i = 0; i < 8; i++) begin
      tick();
      chk("t6_quiet", eip, 1'b0);
    end

    // random traffic
    do_reset();
    wr(2'd0, 32'h8000_000F);
    for (int n = 0; n < 5000; n++) begin
      for (int i = 0; i < NSRC; i++)
        if ($urandom_range(7) == 0) irq_in[i] = ~irq_in[i];
      if ($urandom_range(15) == 0) timer_irq = ~timer_irq;
      a = 2'($urandom_range(3));
      d = $urandom;
      we = ($urandom_range(5) == 0);
      if (we && a == 2'd0 && $urandom_range(3) != 0)
        d = d | 32'h8000_000F;
      if (we && a == 2'd1 && $urandom_range(1) == 0) we = 1'b0;
      eip_reply = eip ? ($urandom_range(2) == 0)
                      : ($urandom_range(19) == 0);
      rst = ($urandom_range(799) == 0);
      tick();
    end
    rst = 1'b0; we = 1'b0; eip_reply = 1'b0;
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
